// File: rtl/ecall_input_ctrl_pkg.sv
// ecall_input_ctrl_pkg
//  Shared definitions for the ECALL read-integer controller.
//  Contents: the ECALL opcode, the keypad codes with special meaning, the
//  controller state type and a small key-classification helper.
//  The optional feature SIGNED_INPUT_EN is handled in ecall_input_ctrl.sv.
package ecall_input_ctrl_pkg;

  // RISC-V SYSTEM opcode; the controller only runs for ECALL.
  localparam logic [6:0] OPC_ECALL   = 7'b1110011;

  // Keypad codes 0-9 are digits; these four act as commands.
  localparam logic [3:0] KEY_BACK    = 4'hA;
  localparam logic [3:0] KEY_NEG     = 4'hB;
  localparam logic [3:0] KEY_CLEAR   = 4'hE;
  localparam logic [3:0] KEY_CONFIRM = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CONVERT = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/ecall_input_ctrl_if.sv
// ecall_input_ctrl_if
//  Bundle between the core/keypad side and the ECALL input controller.
//  Signals:
//   opcode       core -> ctrl   opcode of the instruction at PC
//   key_valid    core -> ctrl   one-cycle key press strobe
//   key_code     core -> ctrl   key identity, valid with key_valid
//   stop_flag    ctrl -> core   freeze PC/register/memory updates
//   keyboard     ctrl -> core   converted value for the a0 write path
//   entry_bcd    ctrl -> core   BCD digits entered so far (LSD in [3:0])
//   entry_count  ctrl -> core   number of digits entered
//   input_active ctrl -> core   entry prompt LED
//  Modports: master (core/keypad side), slave (controller).
interface ecall_input_ctrl_if #(
  parameter int MAX_DIGITS = 8
) ();

  logic [6:0]              opcode;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    stop_flag;
  logic [31:0]             keyboard;
  logic [4*MAX_DIGITS-1:0] entry_bcd;
  logic [3:0]              entry_count;
  logic                    input_active;

  modport master (
    output opcode, key_valid, key_code,
    input  stop_flag, keyboard, entry_bcd, entry_count, input_active
  );

  modport slave (
    input  opcode, key_valid, key_code,
    output stop_flag, keyboard, entry_bcd, entry_count, input_active
  );

endinterface

// File: rtl/ecall_input_ctrl_bcd_to_bin_seq.sv
// bcd_to_bin_seq
//  Iterative BCD-to-binary converter, one digit per cycle, MSD first.
//  A start pulse clears the accumulator and points at the top nibble; each
//  busy cycle computes acc*10 + digit. done is high during the cycle that
//  consumes digit 0, with result already holding the final value, so the
//  caller can register it on that same edge.
//  Ports:
//   clk, reset  clock, synchronous active-high reset
//   start       one-cycle pulse, begin a conversion on the next edge
//   bcd         NDIG BCD digits, LSD in [3:0]; must stay stable while busy
//   done        high in the last conversion cycle
//   result      acc*10 + current digit (final value when done is high)
module bcd_to_bin_seq #(
  parameter int NDIG = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd,
  output logic              done,
  output logic [31:0]       result
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic             busy;
  logic [IDX_W-1:0] idx;
  logic [31:0]      acc;
  logic [3:0]       digit;
  logic [31:0]      next_acc;

  assign digit    = 4'(bcd >> {idx, 2'b00});
  // Multiply by ten as shift-and-add to keep a plain adder in the path.
  assign next_acc = (acc << 3) + (acc << 1) + {28'd0, digit};
  assign done     = busy && (idx == '0);
  assign result   = next_acc;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      idx  <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      idx  <= IDX_W'(NDIG - 1);
      acc  <= '0;
    end else if (busy) begin
      acc <= next_acc;
      if (idx == '0) begin
        busy <= 1'b0;
      end else begin
        idx <= idx - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecall_input_ctrl.sv
// ecall_input_ctrl
//  Services the ECALL read-integer request for the single-cycle core.
//  When ECALL reaches PC the core is frozen, keypad digits are collected,
//  the entry is converted to binary one digit per cycle, and the core is
//  then released for exactly one cycle with the value on keyboard so the
//  ECALL commits it to a0.
//  Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; clears all state
//   bus    ecall_input_ctrl_if.slave (opcode, key_valid, key_code in;
//          stop_flag, keyboard, entry_bcd, entry_count, input_active out)
//  Configuration:
//   SIGNED_INPUT_EN  key B toggles a sign flag during entry; the top BCD
//                    nibble shows 4'hB while negative and the result is
//                    negated. Undefined: B is ignored, no sign logic.
module ecall_input_ctrl
  import ecall_input_ctrl_pkg::*;
#(
  parameter int MAX_DIGITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  ecall_input_ctrl_if.slave   bus
);

  localparam int DW = 4 * MAX_DIGITS;

  state_t          state;
  logic [DW-1:0]   digits;
  logic [3:0]      count;
  logic [31:0]     keyboard_q;
`ifdef SIGNED_INPUT_EN
  logic            neg;
`endif

  logic            conv_start;
  logic            conv_done;
  logic [31:0]     conv_result;

  // The converter is kicked on the same edge that moves COLLECT -> CONVERT,
  // so F press to RELEASE is MAX_DIGITS+1 cycles.
  assign conv_start = (state == ST_COLLECT) && bus.key_valid &&
                      (bus.key_code == KEY_CONFIRM);

  bcd_to_bin_seq #(
    .NDIG (MAX_DIGITS)
  ) u_conv (
    .clk    (clk),
    .reset  (reset),
    .start  (conv_start),
    .bcd    (digits),
    .done   (conv_done),
    .result (conv_result)
  );

  // Combinational on purpose: the ECALL cycle itself must already be frozen.
  assign bus.stop_flag    = !reset &&
                            (((state == ST_IDLE) && (bus.opcode == OPC_ECALL)) ||
                             (state == ST_COLLECT) || (state == ST_CONVERT));
  assign bus.input_active = (state == ST_COLLECT);
  assign bus.entry_count  = count;
  assign bus.keyboard     = keyboard_q;

`ifdef SIGNED_INPUT_EN
  // Overlay the minus marker on the top display nibble while negative.
  assign bus.entry_bcd = neg ?
      ((digits & ~(DW'(4'hF) << (DW - 4))) | (DW'(4'hB) << (DW - 4))) :
      digits;
`else
  assign bus.entry_bcd = digits;
`endif

  // NOTE: the digit buffer is reset along with the FSM because it drives the
  // display directly and must read as zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      digits     <= '0;
      count      <= '0;
      keyboard_q <= '0;
`ifdef SIGNED_INPUT_EN
      neg        <= 1'b0;
`endif
    end else begin
      // NOTE: registers keep their value in branches that do not assign
      // them; that is intended storage in a clocked block, not a latch.
      case (state)
        ST_IDLE: begin
          // A key strobe arriving in this cycle is deliberately dropped.
          if (bus.opcode == OPC_ECALL) begin
            state  <= ST_COLLECT;
            digits <= '0;
            count  <= '0;
`ifdef SIGNED_INPUT_EN
            neg    <= 1'b0;
`endif
          end
        end

        ST_COLLECT: begin
          if (bus.key_valid) begin
            if (is_digit(bus.key_code)) begin
              // Digits beyond MAX_DIGITS are dropped silently.
              if (count < 4'(MAX_DIGITS)) begin
                digits <= (digits << 4) | DW'(bus.key_code);
                count  <= count + 4'd1;
              end
            end else begin
              case (bus.key_code)
                KEY_BACK: begin
                  if (count != 4'd0) begin
                    digits <= digits >> 4;
                    count  <= count - 4'd1;
                  end
                end
`ifdef SIGNED_INPUT_EN
                KEY_NEG: begin
                  neg <= ~neg;
                end
`endif
                KEY_CLEAR: begin
                  digits <= '0;
                  count  <= '0;
                end
                KEY_CONFIRM: begin
                  state <= ST_CONVERT;
                end
                default: ;
              endcase
            end
          end
        end

        ST_CONVERT: begin
          if (conv_done) begin
            state <= ST_RELEASE;
`ifdef SIGNED_INPUT_EN
            keyboard_q <= neg ? (~conv_result + 32'd1) : conv_result;
`else
            keyboard_q <= conv_result;
`endif
          end
        end

        ST_RELEASE: begin
          // The core advances past the ECALL on this edge; a following
          // ECALL can only stall from the next cycle on.
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
